// File: rtl/nib_rx_pkg.sv
// Shared definitions for the serial-to-nibble receiver.
// Holds the FSM state encoding, the default bit period and the frame format
// constants used by nib_rx and nib_bit_timer.
package nib_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int   DEFAULT_CPB = 4;     // clocks per serial bit
    localparam int   DATA_BITS   = 4;     // payload bits per frame, LSB first
    localparam logic START_LEVEL = 1'b0;  // level of the start bit
    localparam logic STOP_LEVEL  = 1'b1;  // level of a good stop bit (and idle)

endpackage

// File: rtl/nib_bit_timer.sv
// Bit-period timer for nib_rx.
// Counts 0..CPB-1 while enabled and wraps to 0. The count is forced to 0 by
// the clear input.
// Ports:
//   clk       - clock, rising edge
//   r         - synchronous active-high reset
//   clr       - force count to 0 at the next edge (overrides enable)
//   en        - advance the count
//   half_tick - count == floor(CPB/2)-1 (mid-bit point of the start bit)
//   full_tick - count == CPB-1 (one full bit period elapsed)
module nib_bit_timer
    import nib_rx_pkg::*;
#(
    parameter int CPB = DEFAULT_CPB
) (
    input  logic clk,
    input  logic r,
    input  logic clr,
    input  logic en,
    output logic half_tick,
    output logic full_tick
);

    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CPB - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign half_tick = (cnt_q == HALF_LAST);
    assign full_tick = (cnt_q == FULL_LAST);

    always_comb begin
        // NOTE: the default assignment first keeps this block free of inferred latches.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = full_tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values.
        if (r) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nib_rx.sv
// Serial-to-nibble receiver.
// Receives frames of 1 start bit (low), 4 data bits LSB first, 1 stop bit
// (high) on an idle-high line. A good frame updates q and pulses valid for
// one cycle; a frame with a low stop bit pulses ferr instead and leaves q.
// Ports:
//   clk   - clock, rising edge
//   r     - synchronous active-high reset, overrides everything
//   sin   - serial input, already synchronous to clk
//   q     - last correctly received nibble (registered)
//   valid - one-cycle strobe, q has just been updated
//   ferr  - one-cycle strobe, the frame just finished had a low stop bit
module nib_rx
    import nib_rx_pkg::*;
#(
    parameter int CPB = DEFAULT_CPB
) (
    input  logic                 clk,
    input  logic                 r,
    input  logic                 sin,
    output logic [DATA_BITS-1:0] q,
    output logic                 valid,
    output logic                 ferr
);

    localparam int BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    state_e                 state_q,   state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   sr_q,      sr_d;
    logic [DATA_BITS-1:0]   q_q,       q_d;
    logic                   valid_q,   valid_d;
    logic                   ferr_q,    ferr_d;

    logic tmr_clr;
    logic half_tick;
    logic full_tick;

    // Holding the timer cleared in IDLE makes the edge that sees the start
    // bit (E0) leave the count at 0, so half_tick lands on E0+H and every
    // later full_tick lands on a data/stop sample edge.
    nib_bit_timer #(
        .CPB (CPB)
    ) u_timer (
        .clk       (clk),
        .r         (r),
        .clr       (tmr_clr),
        .en        (state_q != IDLE),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        q_d       = q_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        tmr_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                tmr_clr = 1'b1;
                if (sin == START_LEVEL) begin
                    state_d = START;
                end
            end
            START: begin
                // Mid-bit re-check rejects short low glitches.
                if (half_tick) begin
                    tmr_clr = 1'b1;
                    if (sin == START_LEVEL) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                // Shift in at the MSB so the first (LSB) bit ends up at bit 0.
                if (full_tick) begin
                    sr_d = {sin, sr_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (full_tick) begin
                    state_d = IDLE;
                    if (sin == STOP_LEVEL) begin
                        q_d     = sr_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            q_q       <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign q     = q_q;
    assign valid = valid_q;
    assign ferr  = ferr_q;

endmodule

// File: doc/nib_rx.md
# nib_rx

Serial-to-nibble receiver that feeds the 4-bit capture register.
- Input is a framed single-wire bit stream: 1 start bit (low), 4 data bits LSB first, 1 stop bit (high); the line idles high.
- Each good frame is reassembled into a 4-bit word and presented with a one-cycle `valid` strobe. That word drives the register's `in` input and `valid` drives its clock-enable side.
- Bad frames produce a one-cycle `ferr` strobe instead.

## Interface
Parameters:
- `CPB`, default 4: clocks per serial bit. Legal values are integers ≥ 2.

Ports:
- `clk`, input, 1 bit: the single clock; everything is on its rising edge.
- `r`, input, 1 bit: synchronous, active-high reset.
- `sin`, input, 1 bit: serial line. It is already synchronous to `clk`; no synchronizer in this block.
- `q`, output, 4 bits: last correctly received nibble.
- `valid`, output, 1 bit: one-cycle strobe, high when `q` has just been updated.
- `ferr`, output, 1 bit: one-cycle strobe, high when a frame had a low stop bit.

## Operation
- Reset (`r`=1 at an edge):
  - state IDLE, bit counter 0, timer 0, shift register 0.
  - `q`=0, `valid`=0, `ferr`=0.
  - Reset overrides every other event at that edge.
- Define H = floor(CPB/2).
- IDLE:
  - `sin`=0 at an edge → START, timer cleared. That edge is E0.
  - Otherwise stay in IDLE.
- START:
  - At E0+H, re-sample `sin`.
  - If 0 → DATA, timer cleared, bit counter 0.
  - If 1 → IDLE (glitch rejected; no strobe).
- DATA:
  - Every CPB cycles, shift `sin` into the shift register LSB first.
  - Bit k (k = 0..3) is sampled at E0+H+(k+1)·CPB.
  - After bit 3 → STOP.
- STOP: at E0+H+5·CPB, sample `sin`.
  - If 1: `q` ← assembled nibble, `valid`=1 for the following cycle.
  - If 0: `ferr`=1 for the following cycle; `q` unchanged.
  - Either way, go to IDLE at that same edge.
- `valid` and `ferr` are never high together. Each clears automatically after one cycle.
- `q` holds its value between frames.
- Reset mid-frame aborts the frame: no strobe, `q`=0.
- `sin` activity during DATA/STOP, other than at the sample edges, is ignored.

## Timing
- Timer width is clog2(CPB). It counts 0..CPB-1 and wraps to 0 on each sample edge.
- Latency: the strobe is visible in the cycle after edge E0+H+5·CPB.
  - For CPB=4: sample edges are E0+2 (start check), E0+6/10/14/18 (data), E0+22 (stop).
  - `valid` is high during the cycle between E0+22 and E0+23.
- Back-to-back frames:
  - IDLE can detect a new start at edge E0+H+5·CPB+1.
  - The minimum frame period of 6·CPB cycles is therefore sustained with no lost frame.
- All outputs are registered. There is no combinational path from `sin` to any output.

## Structure
- Shared package holds:
  - state encoding constants: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - the default CPB;
  - frame constants: data bits = 4, start level = 0, stop level = 1.
- One sub-module, `nib_bit_timer`:
  - parameterised by CPB;
  - inputs: clear and enable;
  - outputs: `half_tick` (count = H-1) and `full_tick` (count = CPB-1).
- The FSM, shift register and output registers stay in `nib_rx`.

## Test plan
All scenarios use CPB=4. "Frame" means start, data LSB first, stop.

1. Reset: `r`=1 for 2 cycles with `sin`=1 → `q`=4'h0, `valid`=0, `ferr`=0; stays so while `sin` idles high.
2. Good frame 4'h5 (bits 1,0,1,0, stop 1) → `valid`=1 for exactly the cycle after E0+22, `q`=4'h5, `ferr`=0.
3. Glitch: `sin`=0 for 1 cycle, then high → no strobe, back in IDLE. A following frame 4'hA → `q`=4'hA.
4. Framing error: frame 4'hC with stop bit 0 after `q`=4'h5 → `ferr`=1 for one cycle, `valid`=0, `q` stays 4'h5.
5. Reset mid-frame: `r`=1 at E0+10 during frame 4'h9 → no strobe, `q`=4'h0. A following frame 4'h3 → `q`=4'h3 with `valid`.
6. Back-to-back: frame 4'hF, then frame 4'h0 with its start bit beginning immediately after the stop bit:
   - two `valid` pulses exactly 24 cycles apart;
   - `q`=4'hF, then 4'h0.
